branch_hazard_sequencer: RTL and testbench

- Sequences the ID-stage branch resolution path of the five-stage MIPS pipeline.
- Detects when a beq/bne in ID reads a register still being produced in EX or MEM.
- Holds PC and IF/ID, and injects ID/EX bubbles, for exactly the required number of cycles.
- Then selects ID-stage comparator forwarding and flushes IF/ID on a taken branch.
- Keeps saturating performance counters for branch stall cycles and taken-branch flushes.

---
 rtl/branch_hazard_sequencer_pkg.sv | 28 ++
 rtl/branch_hazard_sequencer_dep_check.sv | 50 +++++
 rtl/branch_hazard_sequencer.sv | 176 +++++++++++++++++
 tb/tb_branch_hazard_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_hazard_sequencer_pkg.sv
// Shared definitions for the ID-stage branch hazard sequencer.
//   - Branch field encodings seen on ID_Branch.
//   - Sequencer state encodings (kept as plain localparams so they can be
//     compared against legacy-encoded debug traces).
//   - REG_ZERO: register $zero, which never creates a dependence.
//   - seq_dbg_t: snapshot of the sequencer state for external checkers.
package branch_hazard_sequencer_pkg;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [0:0] state;
        logic [1:0] remain;
    } seq_dbg_t;

    // Only beq and bne are resolved here; 2'b11 behaves as a non-branch.
    function automatic logic is_branch(input logic [1:0] br);
        return (br == BR_BEQ) || (br == BR_BNE);
    endfunction

endpackage

// File: rtl/branch_hazard_sequencer_dep_check.sv
// branch_dep_check: combinational dependence check for a branch in ID.
// Ports:
//   id_branch                       branch field of the ID instruction
//   rs, rt                          source registers read by the comparator
//   ex_regwrite/ex_memread/ex_wreg  producer currently in EX
//   mem_regwrite/mem_memread/mem_wreg producer currently in MEM
//   need                            stall cycles required before resolving (0..2)
module branch_dep_check
    import branch_hazard_sequencer_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [1:0]       id_branch,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_wreg,
    output logic [1:0]       need
);

    logic ex_hit;
    logic mem_hit;

    // A destination of $zero is never a real producer.
    always_comb begin
        ex_hit  = (ex_wreg != REG_W'(REG_ZERO)) &&
                  ((rs == ex_wreg) || (rt == ex_wreg));
        mem_hit = (mem_wreg != REG_W'(REG_ZERO)) &&
                  ((rs == mem_wreg) || (rt == mem_wreg));
    end

    // Priority: a load in EX needs the most time, so it wins over the others.
    always_comb begin
        need = 2'd0;
        if (is_branch(id_branch)) begin
            if (ex_regwrite && ex_memread && ex_hit) begin
                need = 2'd2;
            end else if (ex_regwrite && ex_hit) begin
                need = 2'd1;
            end else if (mem_regwrite && mem_memread && mem_hit) begin
                need = 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_hazard_sequencer.sv
// branch_hazard_sequencer: stalls a beq/bne in ID until its operands can be
// compared, then resolves it (comparator forwarding + IF/ID flush on taken).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ID_Branch             00 none, 01 beq, 10 bne, 11 none
//   IF_ID_Rs/Rt           comparator source registers
//   ID_EX_*/EX_MEM_*      producer info for the EX and MEM stages
//   PCSrc                 branch outcome, valid in the resolve cycle
//   PCWrite/IF_ID_Write   hold PC and IF/ID when low
//   ID_EX_Bubble          zero ID/EX control fields
//   IF_ID_Flush           squash the fall-through fetch
//   BrFwdA/BrFwdB         comparator operand from EX/MEM ALU result
//   Busy                  high on every stall cycle
//   StallCount/FlushCount saturating performance counters
// Handshake: none; every output is a same-cycle function of state and inputs.
module branch_hazard_sequencer
    import branch_hazard_sequencer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ID_Branch,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_WriteReg,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_WriteReg,
    input  logic             PCSrc,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             BrFwdA,
    output logic             BrFwdB,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic [0:0]       state_q,     state_d;
    logic [1:0]       remain_q,    remain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [1:0] need;
    logic       is_br;
    logic       stall;
    logic       resolve;
    logic       fwd_a_hit;
    logic       fwd_b_hit;
    seq_dbg_t   dbg;

    branch_dep_check #(.REG_W(REG_W)) u_dep (
        .id_branch    (ID_Branch),
        .rs           (IF_ID_Rs),
        .rt           (IF_ID_Rt),
        .ex_regwrite  (ID_EX_RegWrite),
        .ex_memread   (ID_EX_MemRead),
        .ex_wreg      (ID_EX_WriteReg),
        .mem_regwrite (EX_MEM_RegWrite),
        .mem_memread  (EX_MEM_MemRead),
        .mem_wreg     (EX_MEM_WriteReg),
        .need         (need)
    );

    // Debug snapshot for bound checkers.
    always_comb begin
        dbg.state  = state_q;
        dbg.remain = remain_q;
    end

    // Sequencer: decide stall vs resolve for this cycle and the next state.
    always_comb begin
        is_br    = is_branch(ID_Branch);
        state_d  = state_q;
        remain_d = remain_q;
        stall    = 1'b0;
        resolve  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_br) begin
                    if (need != 2'd0) begin
                        stall    = 1'b1;
                        state_d  = ST_STALL;
                        remain_d = need - 2'd1;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            ST_STALL: begin
                if (remain_q != 2'd0) begin
                    stall    = 1'b1;
                    remain_d = remain_q - 2'd1;
                end else begin
                    // Operands are now available; resolve without rechecking.
                    resolve  = 1'b1;
                    state_d  = ST_IDLE;
                    remain_d = 2'd0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                remain_d = 2'd0;
            end
        endcase
    end

    // Only ALU results in MEM can be forwarded; a load there is not ready.
    always_comb begin
        fwd_a_hit = EX_MEM_RegWrite && !EX_MEM_MemRead &&
                    (EX_MEM_WriteReg != REG_W'(REG_ZERO)) &&
                    (IF_ID_Rs == EX_MEM_WriteReg);
        fwd_b_hit = EX_MEM_RegWrite && !EX_MEM_MemRead &&
                    (EX_MEM_WriteReg != REG_W'(REG_ZERO)) &&
                    (IF_ID_Rt == EX_MEM_WriteReg);
    end

    // Output drive; reset forces the pass-through pattern.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        BrFwdA       = 1'b0;
        BrFwdB       = 1'b0;
        Busy         = 1'b0;
        if (rst_n) begin
            if (stall) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                Busy         = 1'b1;
            end else if (resolve) begin
                IF_ID_Flush = is_br && PCSrc;
                BrFwdA      = fwd_a_hit;
                BrFwdB      = fwd_b_hit;
            end
        end
    end

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Busy && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IF_ID_Flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remain_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_sequencer.sv
// Bench for branch_hazard_sequencer: directed pipeline snapshots, a
// cycles-owed reference model checked on every falling edge, and literal
// expectations taken from hand-worked branch sequences.
module tb_branch_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ID_Branch = 2'b00;
    logic [4:0]  IF_ID_Rs = 5'd0;
    logic [4:0]  IF_ID_Rt = 5'd0;
    logic        ID_EX_RegWrite = 1'b0;
    logic        ID_EX_MemRead = 1'b0;
    logic [4:0]  ID_EX_WriteReg = 5'd0;
    logic        EX_MEM_RegWrite = 1'b0;
    logic        EX_MEM_MemRead = 1'b0;
    logic [4:0]  EX_MEM_WriteReg = 5'd0;
    logic        PCSrc = 1'b0;
    logic        PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
    logic        BrFwdA, BrFwdB, Busy;
    logic [15:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;

    // Clock / reset
    always #5 clk = ~clk;

    branch_hazard_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_Branch       (ID_Branch),
        .IF_ID_Rs        (IF_ID_Rs),
        .IF_ID_Rt        (IF_ID_Rt),
        .ID_EX_RegWrite  (ID_EX_RegWrite),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .ID_EX_WriteReg  (ID_EX_WriteReg),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .EX_MEM_MemRead  (EX_MEM_MemRead),
        .EX_MEM_WriteReg (EX_MEM_WriteReg),
        .PCSrc           (PCSrc),
        .PCWrite         (PCWrite),
        .IF_ID_Write     (IF_ID_Write),
        .ID_EX_Bubble    (ID_EX_Bubble),
        .IF_ID_Flush     (IF_ID_Flush),
        .BrFwdA          (BrFwdA),
        .BrFwdB          (BrFwdB),
        .Busy            (Busy),
        .StallCount      (StallCount),
        .FlushCount      (FlushCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: counts stall cycles still owed to the branch in ID.
    int          owed_m = 0, owed_n;
    bit          res_m = 1'b0, res_n;
    logic [15:0] sc_m = 16'd0, sc_n;
    logic [15:0] fc_m = 16'd0, fc_n;
    bit          preload_req = 1'b0;

    function automatic int model_need();
        bit br;
        bit ex_dep, mem_dep;
        br      = (ID_Branch == 2'b01) || (ID_Branch == 2'b10);
        ex_dep  = (ID_EX_WriteReg != 0) &&
                  (ID_EX_WriteReg == IF_ID_Rs || ID_EX_WriteReg == IF_ID_Rt);
        mem_dep = (EX_MEM_WriteReg != 0) &&
                  (EX_MEM_WriteReg == IF_ID_Rs || EX_MEM_WriteReg == IF_ID_Rt);
        if (!br) return 0;
        if (ID_EX_RegWrite && ID_EX_MemRead && ex_dep) return 2;
        if (ID_EX_RegWrite && ex_dep) return 1;
        if (EX_MEM_RegWrite && EX_MEM_MemRead && mem_dep) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit          br, e_stall, e_res, e_flush, e_fa, e_fb;
        int          eff;
        logic [15:0] sc_cur;
        br      = (ID_Branch == 2'b01) || (ID_Branch == 2'b10);
        sc_cur  = preload_req ? 16'hFFFE : sc_m;
        e_stall = 1'b0; e_res = 1'b0; e_flush = 1'b0; e_fa = 1'b0; e_fb = 1'b0;
        owed_n  = 0; res_n = 1'b0; sc_n = sc_cur; fc_n = fc_m;
        if (!rst_n) begin
            sc_n = 16'd0; fc_n = 16'd0;
        end else begin
            eff = owed_m;
            if (owed_m == 0 && !res_m && br) eff = model_need();
            if (eff > 0) begin
                e_stall = 1'b1;
                owed_n  = eff - 1;
                res_n   = (eff == 1);
                if (sc_cur != 16'hFFFF) sc_n = sc_cur + 16'd1;
            end else begin
                e_res   = res_m || br;
                e_flush = e_res && br && PCSrc;
                e_fa    = e_res && EX_MEM_RegWrite && !EX_MEM_MemRead &&
                          EX_MEM_WriteReg != 0 && EX_MEM_WriteReg == IF_ID_Rs;
                e_fb    = e_res && EX_MEM_RegWrite && !EX_MEM_MemRead &&
                          EX_MEM_WriteReg != 0 && EX_MEM_WriteReg == IF_ID_Rt;
                if (e_flush && fc_m != 16'hFFFF) fc_n = fc_m + 16'd1;
            end
        end
        check("model_PCWrite",      32'(PCWrite),      32'(!e_stall));
        check("model_IF_ID_Write",  32'(IF_ID_Write),  32'(!e_stall));
        check("model_ID_EX_Bubble", 32'(ID_EX_Bubble), 32'(e_stall));
        check("model_Busy",         32'(Busy),         32'(e_stall));
        check("model_IF_ID_Flush",  32'(IF_ID_Flush),  32'(e_flush));
        check("model_BrFwdA",       32'(BrFwdA),       32'(e_fa));
        check("model_BrFwdB",       32'(BrFwdB),       32'(e_fb));
        check("model_StallCount",   32'(StallCount),   32'(sc_cur));
        check("model_FlushCount",   32'(FlushCount),   32'(fc_m));
    end

    always @(posedge clk) begin
        owed_m = owed_n; res_m = res_n; sc_m = sc_n; fc_m = fc_n;
    end

    // Driver: apply one pipeline snapshot just after the rising edge and
    // return at the falling edge, where outputs are stable.
    task automatic drive(input logic r, input logic [1:0] br,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic exw, input logic exr, input logic [4:0] exd,
                         input logic mw, input logic mr, input logic [4:0] md,
                         input logic pc);
        @(posedge clk);
        #1;
        preload_req     = 1'b0;
        rst_n           = r;
        ID_Branch       = br;
        IF_ID_Rs        = rs;
        IF_ID_Rt        = rt;
        ID_EX_RegWrite  = exw;
        ID_EX_MemRead   = exr;
        ID_EX_WriteReg  = exd;
        EX_MEM_RegWrite = mw;
        EX_MEM_MemRead  = mr;
        EX_MEM_WriteReg = md;
        PCSrc           = pc;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive(1, 2'b00, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
    endtask

    initial begin
        // Reset
        @(negedge clk);
        check("reset_PCWrite", 32'(PCWrite), 32'd1);
        check("reset_Busy", 32'(Busy), 32'd0);
        check("reset_StallCount", 32'(StallCount), 32'd0);
        drive(0, 2'b00, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        idle_cycle();

        // lw $1 in EX; beq $1,$2; taken
        drive(1, 2'b01, 5'd1, 5'd2, 1, 1, 5'd1, 0, 0, 5'd0, 1);
        check("lw_beq_stall1_Busy", 32'(Busy), 32'd1);
        check("lw_beq_stall1_PCWrite", 32'(PCWrite), 32'd0);
        drive(1, 2'b01, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 5'd1, 1);
        check("lw_beq_stall2_Busy", 32'(Busy), 32'd1);
        drive(1, 2'b01, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        check("lw_beq_resolve_Flush", 32'(IF_ID_Flush), 32'd1);
        check("lw_beq_resolve_FwdA", 32'(BrFwdA), 32'd0);
        check("lw_beq_resolve_Busy", 32'(Busy), 32'd0);
        idle_cycle();
        check("lw_beq_StallCount", 32'(StallCount), 32'd2);
        check("lw_beq_FlushCount", 32'(FlushCount), 32'd1);

        // add $3 in EX; bne $4,$3; not taken
        drive(1, 2'b10, 5'd4, 5'd3, 1, 0, 5'd3, 0, 0, 5'd0, 0);
        check("add_bne_stall_Busy", 32'(Busy), 32'd1);
        drive(1, 2'b10, 5'd4, 5'd3, 0, 0, 5'd0, 1, 0, 5'd3, 0);
        check("add_bne_resolve_FwdB", 32'(BrFwdB), 32'd1);
        check("add_bne_resolve_FwdA", 32'(BrFwdA), 32'd0);
        check("add_bne_resolve_Flush", 32'(IF_ID_Flush), 32'd0);
        check("add_bne_resolve_PCWrite", 32'(PCWrite), 32'd1);
        idle_cycle();
        check("add_bne_StallCount", 32'(StallCount), 32'd3);

        // beq $0,$0 with add $0 in EX: immediate taken
        drive(1, 2'b01, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0, 5'd0, 1);
        check("zero_beq_Busy", 32'(Busy), 32'd0);
        check("zero_beq_Flush", 32'(IF_ID_Flush), 32'd1);
        idle_cycle();
        check("zero_beq_FlushCount", 32'(FlushCount), 32'd2);

        // ID_Branch=11 with matching load in EX
        drive(1, 2'b11, 5'd6, 5'd7, 1, 1, 5'd6, 0, 0, 5'd0, 1);
        check("br11_Busy", 32'(Busy), 32'd0);
        check("br11_Flush", 32'(IF_ID_Flush), 32'd0);
        check("br11_PCWrite", 32'(PCWrite), 32'd1);

        // Load in MEM feeding beq: one stall, no forward from a load
        drive(1, 2'b01, 5'd5, 5'd9, 0, 0, 5'd0, 1, 1, 5'd5, 0);
        check("mem_lw_stall_Busy", 32'(Busy), 32'd1);
        drive(1, 2'b01, 5'd5, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        check("mem_lw_resolve_Busy", 32'(Busy), 32'd0);
        idle_cycle();
        check("mem_lw_StallCount", 32'(StallCount), 32'd4);

        // Reset in the middle of a two-cycle stall
        drive(1, 2'b01, 5'd1, 5'd2, 1, 1, 5'd1, 0, 0, 5'd0, 0);
        drive(0, 2'b01, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 5'd1, 0);
        check("rst_mid_PCWrite", 32'(PCWrite), 32'd1);
        check("rst_mid_Busy", 32'(Busy), 32'd0);
        drive(1, 2'b01, 5'd8, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        check("after_rst_PCWrite", 32'(PCWrite), 32'd1);
        check("after_rst_Busy", 32'(Busy), 32'd0);
        check("after_rst_StallCount", 32'(StallCount), 32'd0);
        check("after_rst_FlushCount", 32'(FlushCount), 32'd0);

        // Saturation: preload near all-ones, then two stall cycles
        @(posedge clk);
        #1;
        preload_req = 1'b1;
        ID_Branch   = 2'b00;
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        @(negedge clk);
        drive(1, 2'b01, 5'd1, 5'd2, 1, 1, 5'd1, 0, 0, 5'd0, 0);
        check("sat_pre_StallCount", 32'(StallCount), 32'hFFFE);
        drive(1, 2'b01, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 5'd1, 0);
        check("sat_hit_StallCount", 32'(StallCount), 32'hFFFF);
        drive(1, 2'b01, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        check("sat_hold_StallCount", 32'(StallCount), 32'hFFFF);
        idle_cycle();
        check("sat_final_StallCount", 32'(StallCount), 32'hFFFF);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
